// File: rtl/line_window_scanner_if.sv
// Request, board-RAM read and judge handshake bundle for line_window_scanner.
// The scanner sits on the slave side; the environment (requester, board RAM,
// chess-form judge) sits on the master side.
interface line_window_scanner_if;
    // request
    logic        start;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        player;
    // board RAM read port
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [1:0]  rd_data;
    // judge handshake
    logic [8:0]  win_a;
    logic [8:0]  win_b;
    logic [1:0]  win_dir;
    logic        win_valid;
    logic [2:0]  type_in;
    // results / status
    logic [11:0] types_out;
    logic [2:0]  best_type;
    logic        bad_pos;
    logic        busy;
    logic        done;

    modport slave (
        input  start, row, col, player, rd_data, type_in,
        output rd_en, rd_addr, win_a, win_b, win_dir, win_valid,
               types_out, best_type, bad_pos, busy, done
    );

    modport master (
        output start, row, col, player, rd_data, type_in,
        input  rd_en, rd_addr, win_a, win_b, win_dir, win_valid,
               types_out, best_type, bad_pos, busy, done
    );
endinterface

// File: rtl/line_window_scanner.sv
// line_window_scanner: reads the 9-cell horizontal, vertical, diagonal and
// anti-diagonal windows around a candidate cell from the board RAM, presents
// each as own/opponent masks to the chess-form judge and collects the four
// returned form types plus their maximum.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start
//   ISSUE | one window slot per cycle (read, off-board or candidate slot)
//   DRAIN | last read returns; window copied to win_a/win_b
//   HOLD  | window held for HOLD_CYC cycles, type sampled on the last edge
//   DONE  | results published, one-cycle done pulse
module line_window_scanner #(
    parameter int BOARD_N  = 15,
    parameter int HOLD_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    line_window_scanner_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, HOLD, DONE} state_t;
    typedef enum logic [1:0] {K_READ, K_OFF, K_CTR} slot_kind_t;

    localparam logic signed [5:0] LIM   = 6'(BOARD_N - 1);
    localparam logic [3:0]        LIM4  = 4'(BOARD_N - 1);
    localparam logic [7:0]        N8    = 8'(BOARD_N);
    localparam logic [3:0]        HLOAD = 4'(HOLD_CYC - 1);

    state_t      state, state_nx;
    logic [3:0]  row_q, col_q;
    logic        player_q;
    logic [1:0]  dir;
    logic [3:0]  idx;
    logic [3:0]  hold_cnt;

    // slot issued last cycle, whose RAM data (if any) arrives this cycle
    logic        p_valid;
    logic [3:0]  p_idx;
    slot_kind_t  p_kind;

    logic [8:0]  wa, wb, wa_nx, wb_nx;
    logic [2:0]  shadow [4];

    logic signed [5:0] k, dk_r, dk_c, pr, pc;
    logic        off_board, center, bad_req, hold_tc;
    logic [7:0]  addr_calc;
    logic [1:0]  own_code, opp_code;
    logic        slot_a, slot_b;

    function automatic logic [2:0] max2(input logic [2:0] a, input logic [2:0] b);
        return (a > b) ? a : b;
    endfunction

    assign bad_req = (bus.row > LIM4) || (bus.col > LIM4);
    assign hold_tc = (hold_cnt == 4'd0);

    // board position of the slot currently being issued
    always_comb begin
        k    = $signed({2'b00, idx}) - 6'sd4;
        dk_r = 6'sd0;
        dk_c = 6'sd0;
        case (dir)
            2'd0:    dk_c = k;
            2'd1:    dk_r = k;
            2'd2:    begin dk_r = k; dk_c = k;  end
            default: begin dk_r = k; dk_c = -k; end
        endcase
        pr        = $signed({2'b00, row_q}) + dk_r;
        pc        = $signed({2'b00, col_q}) + dk_c;
        off_board = (pr < 6'sd0) || (pr > LIM) || (pc < 6'sd0) || (pc > LIM);
        center    = (idx == 4'd4);
        addr_calc = {4'd0, pr[3:0]} * N8 + {4'd0, pc[3:0]};
    end

    assign bus.rd_en     = (state == ISSUE) && !off_board && !center;
    assign bus.rd_addr   = bus.rd_en ? addr_calc : 8'd0;
    assign bus.win_valid = (state == HOLD);
    assign bus.win_dir   = dir;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);

    // merge the slot returning this cycle into the window being built
    always_comb begin
        own_code = player_q ? 2'b10 : 2'b01;
        opp_code = player_q ? 2'b01 : 2'b10;
        case (p_kind)
            K_CTR:   begin slot_a = 1'b1; slot_b = 1'b0; end
            K_OFF:   begin slot_a = 1'b0; slot_b = 1'b1; end
            default: begin
                slot_a = (bus.rd_data == own_code);
                slot_b = (bus.rd_data == opp_code);
            end
        endcase
        wa_nx = wa;
        wb_nx = wb;
        if (p_valid) begin
            wa_nx[p_idx] = slot_a;
            wb_nx[p_idx] = slot_b;
        end
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (bus.start) state_nx = bad_req ? DONE : ISSUE;
            ISSUE: if (idx == 4'd8) state_nx = DRAIN;
            DRAIN: state_nx = HOLD;
            HOLD:  if (hold_tc) state_nx = (dir == 2'd3) ? DONE : ISSUE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // request latch, slot pipeline, window assembly and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q         <= 4'd0;
            col_q         <= 4'd0;
            player_q      <= 1'b0;
            dir           <= 2'd0;
            idx           <= 4'd0;
            hold_cnt      <= 4'd0;
            p_valid       <= 1'b0;
            p_idx         <= 4'd0;
            p_kind        <= K_READ;
            wa            <= 9'd0;
            wb            <= 9'd0;
            bus.win_a     <= 9'd0;
            bus.win_b     <= 9'd0;
            bus.types_out <= 12'd0;
            bus.best_type <= 3'd0;
            bus.bad_pos   <= 1'b0;
            for (int s = 0; s < 4; s++) shadow[s] <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        row_q    <= bus.row;
                        col_q    <= bus.col;
                        player_q <= bus.player;
                        dir      <= 2'd0;
                        idx      <= 4'd0;
                        p_valid  <= 1'b0;
                        if (bad_req) begin
                            bus.types_out <= 12'd0;
                            bus.best_type <= 3'd0;
                            bus.bad_pos   <= 1'b1;
                        end else begin
                            bus.bad_pos   <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    p_valid <= 1'b1;
                    p_idx   <= idx;
                    p_kind  <= center ? K_CTR : (off_board ? K_OFF : K_READ);
                    idx     <= (idx == 4'd8) ? 4'd0 : idx + 4'd1;
                    wa      <= wa_nx;
                    wb      <= wb_nx;
                end
                DRAIN: begin
                    p_valid   <= 1'b0;
                    wa        <= wa_nx;
                    wb        <= wb_nx;
                    bus.win_a <= wa_nx;
                    bus.win_b <= wb_nx;
                    hold_cnt  <= HLOAD;
                end
                HOLD: begin
                    if (hold_tc) begin
                        shadow[dir] <= bus.type_in;
                        if (dir == 2'd3) begin
                            bus.types_out <= {bus.type_in, shadow[2], shadow[1], shadow[0]};
                            bus.best_type <= max2(max2(bus.type_in, shadow[2]),
                                                  max2(shadow[1], shadow[0]));
                        end else begin
                            dir <= dir + 2'd1;
                            idx <= 4'd0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_line_window_scanner.sv
// Directed bench for line_window_scanner: board RAM and judge models, a
// vector table of complete requests, and hand-written restart/reset cases.
module tb_line_window_scanner;
    logic clk;
    logic rst;
    line_window_scanner_if bus();

    line_window_scanner #(.BOARD_N(15), .HOLD_CYC(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       board [225];
    logic [3:0][2:0]  judge;
    int checks = 0;
    int errors = 0;

    // board RAM: one-cycle read latency
    always @(posedge clk)
        bus.rd_data <= (bus.rd_en && bus.rd_addr < 8'd225) ? board[bus.rd_addr] : 2'b00;

    // judge: fixed per-direction answer while a window is presented
    assign bus.type_in = bus.win_valid ? judge[bus.win_dir] : 3'd0;

    typedef struct {
        logic [3:0]      row;
        logic [3:0]      col;
        logic            player;
        int              board_id;
        logic [3:0][2:0] jr;
        logic [11:0]     exp_types;
        logic [2:0]      exp_best;
        logic            exp_bad;
        int              exp_done;
        int              exp_rd;
        logic [3:0][8:0] ea;
        logic [3:0][8:0] eb;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_board(input int id);
        for (int i = 0; i < 225; i++) board[i] = 2'b00;
        case (id)
            1: for (int c = 3; c <= 6; c++) board[7*15+c] = 2'b01;
            2: begin
                board[13*15+13] = 2'b10;
                board[14*15+12] = 2'b01;
                board[10*15+14] = 2'b10;
            end
            3: begin
                board[7*15+8] = 2'b11;
                board[8*15+8] = 2'b10;
                board[6*15+8] = 2'b01;
            end
            default: ;
        endcase
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_rd_en"},     32'(bus.rd_en), 0);
        chk({tag, "_rd_addr"},   32'(bus.rd_addr), 0);
        chk({tag, "_win_ab"},    32'({bus.win_a, bus.win_b}), 0);
        chk({tag, "_win_valid"}, 32'(bus.win_valid), 0);
        chk({tag, "_types"},     32'(bus.types_out), 0);
        chk({tag, "_best"},      32'(bus.best_type), 0);
        chk({tag, "_bad_pos"},   32'(bus.bad_pos), 0);
        chk({tag, "_busy_done"}, 32'({bus.busy, bus.done}), 0);
    endtask

    // Runs one request. restart_cyc: cycle in which a second start is pulsed
    // (0 = none). rst_cyc: cycle in which reset is asserted (0 = none).
    task automatic run_vec(input vec_t v, input int restart_cyc, input int rst_cyc);
        int cyc, rd_cnt, addr_bad, hold_cyc, unstable, done_cnt, done_cyc;
        logic [8:0] ca [4];
        logic [8:0] cb [4];
        logic prev_valid;
        rd_cnt = 0; addr_bad = 0; hold_cyc = 0; unstable = 0;
        done_cnt = 0; done_cyc = 0; prev_valid = 1'b0;
        for (int d = 0; d < 4; d++) begin ca[d] = 9'h0; cb[d] = 9'h0; end
        load_board(v.board_id);
        judge = v.jr;
        @(negedge clk);
        bus.row = v.row; bus.col = v.col; bus.player = v.player; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.row = 4'd1; bus.col = 4'd2; bus.player = ~v.player;
        cyc = 1;
        while (cyc < 200) begin
            if (bus.rd_en) rd_cnt++;
            if (!bus.rd_en && bus.rd_addr != 8'd0) addr_bad++;
            if (bus.win_valid) begin
                hold_cyc++;
                if (!prev_valid) begin
                    ca[bus.win_dir] = bus.win_a;
                    cb[bus.win_dir] = bus.win_b;
                end else if (bus.win_a != ca[bus.win_dir] || bus.win_b != cb[bus.win_dir]) begin
                    unstable++;
                end
            end
            prev_valid = bus.win_valid;
            if (bus.done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (cyc == 1) chk("busy_cycle1", 32'(bus.busy), 1);
            if (cyc == restart_cyc) begin
                bus.start = 1'b1; bus.row = 4'd0; bus.col = 4'd0;
            end else begin
                bus.start = 1'b0;
            end
            if (cyc == rst_cyc) begin
                rst = 1'b1;
                #1;
                check_zero_outputs("async_rst");
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    if (bus.done) done_cnt++;
                end
                rst = 1'b0;
                for (int j = 0; j < 60; j++) begin
                    @(negedge clk);
                    if (bus.done) done_cnt++;
                end
                chk("aborted_no_done", 32'(done_cnt), 0);
                return;
            end
            if (done_cyc != 0 && cyc >= done_cyc + 3) break;
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        chk("done_cycle", 32'(done_cyc), 32'(v.exp_done));
        chk("done_count", 32'(done_cnt), 1);
        chk("types_out",  32'(bus.types_out), 32'(v.exp_types));
        chk("best_type",  32'(bus.best_type), 32'(v.exp_best));
        chk("bad_pos",    32'(bus.bad_pos), 32'(v.exp_bad));
        chk("rd_en_count", 32'(rd_cnt), 32'(v.exp_rd));
        chk("rd_addr_idle_zero", 32'(addr_bad), 0);
        chk("hold_cycles", 32'(hold_cyc), v.exp_bad ? 0 : 8);
        chk("window_stable", 32'(unstable), 0);
        chk("busy_after", 32'(bus.busy), 0);
        if (!v.exp_bad) begin
            for (int d = 0; d < 4; d++) begin
                chk($sformatf("win_a_dir%0d", d), 32'(ca[d]), 32'(v.ea[d]));
                chk($sformatf("win_b_dir%0d", d), 32'(cb[d]), 32'(v.eb[d]));
            end
        end
    endtask

    initial begin
        // row col pl board judge{d3..d0} types best bad done rd win_a{d3..d0} win_b{d3..d0}
        vecs[0] = '{4'd7, 4'd7, 1'b0, 0, {3'd0,3'd0,3'd0,3'd0}, 12'h000, 3'd0, 1'b0, 49, 32,
                    {9'h010,9'h010,9'h010,9'h010}, {9'h000,9'h000,9'h000,9'h000}};
        vecs[1] = '{4'd7, 4'd7, 1'b0, 1, {3'd1,3'd5,3'd2,3'd7}, 12'h357, 3'd7, 1'b0, 49, 32,
                    {9'h010,9'h010,9'h010,9'h01F}, {9'h000,9'h000,9'h000,9'h000}};
        vecs[2] = '{4'd15, 4'd0, 1'b0, 1, {3'd7,3'd7,3'd7,3'd7}, 12'h000, 3'd0, 1'b1, 1, 0,
                    {9'h0,9'h0,9'h0,9'h0}, {9'h0,9'h0,9'h0,9'h0}};
        vecs[3] = '{4'd7, 4'd7, 1'b1, 1, {3'd4,3'd0,3'd6,3'd3}, 12'h833, 3'd6, 1'b0, 49, 32,
                    {9'h010,9'h010,9'h010,9'h010}, {9'h000,9'h000,9'h000,9'h00F}};
        vecs[4] = '{4'd0, 4'd0, 1'b0, 0, {3'd2,3'd2,3'd2,3'd2}, 12'h492, 3'd2, 1'b0, 49, 12,
                    {9'h010,9'h010,9'h010,9'h010}, {9'h1EF,9'h00F,9'h00F,9'h00F}};
        vecs[5] = '{4'd14, 4'd14, 1'b1, 2, {3'd3,3'd2,3'd1,3'd0}, 12'h688, 3'd3, 1'b0, 49, 12,
                    {9'h010,9'h018,9'h011,9'h010}, {9'h1EF,9'h1E0,9'h1E0,9'h1E4}};
        vecs[6] = '{4'd3, 4'd15, 1'b1, 2, {3'd7,3'd7,3'd7,3'd7}, 12'h000, 3'd0, 1'b1, 1, 0,
                    {9'h0,9'h0,9'h0,9'h0}, {9'h0,9'h0,9'h0,9'h0}};
        vecs[7] = '{4'd7, 4'd7, 1'b0, 3, {3'd4,3'd4,3'd4,3'd4}, 12'h924, 3'd4, 1'b0, 49, 32,
                    {9'h018,9'h010,9'h010,9'h010}, {9'h000,9'h020,9'h000,9'h000}};

        rst = 1'b1;
        bus.start = 1'b0; bus.row = 4'd0; bus.col = 4'd0; bus.player = 1'b0;
        judge = '0;
        load_board(0);
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], 0, 0);

        // second start mid-request must be ignored
        run_vec(vecs[1], 20, 0);
        // reset during dir2, then a clean request
        run_vec(vecs[1], 0, 25);
        run_vec(vecs[7], 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
